// File: rtl/seq_shift_unit.sv
// Multi-mode sequential shifter: LSL/LSR/ASR/SPL/ROL/ROR with range clamping,
// up to STEP bit positions per clock, and a start/ready/busy/done handshake.
module seq_shift_unit #(
  parameter int N    = 8,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  output logic         busy,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   mode,
  output logic [N-1:0] result,
  output logic         done,
  output logic         error
);

  localparam int LW = $clog2(N);
  localparam int CW = LW + 1;

  localparam logic [N-1:0]  N_VEC  = N'(N);
  localparam logic [CW-1:0] N_CNT  = CW'(N);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_SPL = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  work;
  logic [2:0]    mode_q;
  logic          err_q;
  logic          sign_q;
  logic [CW-1:0] cnt;

  logic [CW-1:0]  cnt_init;
  logic           err_init;
  logic [CW-1:0]  step_amt;
  logic [CW-1:0]  cnt_next;
  logic [N-1:0]   lsl_v;
  logic [2*N-1:0] rol_w;
  logic [2*N-1:0] ror_w;
  logic [N-1:0]   shifted;

  // Request decode: rotates wrap the amount, the other modes clamp it at N.
  always_comb begin
    err_init = B[N-1] | (mode[2:1] == 2'b11);
    if (mode[2:1] == 2'b10) begin
      cnt_init = {1'b0, B[LW-1:0]};
    end else if (B >= N_VEC) begin
      cnt_init = N_CNT;
    end else begin
      cnt_init = B[CW-1:0];
    end
  end

  // One step of the datapath: shift the working register by min(STEP, cnt).
  // NOTE: every always_comb output gets a default before the case, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    step_amt = (cnt > STEP_C) ? STEP_C : cnt;
    cnt_next = cnt - step_amt;
    lsl_v    = work << step_amt;
    rol_w    = {work, work} << step_amt;
    ror_w    = {work, work} >> step_amt;
    shifted  = work;
    case (mode_q)
      M_LSL:   shifted = lsl_v;
      M_LSR:   shifted = work >> step_amt;
      M_ASR:   shifted = $signed(work) >>> step_amt;
      M_SPL:   shifted = {sign_q, lsl_v[N-2:0]};
      M_ROL:   shifted = rol_w[2*N-1:N];
      M_ROR:   shifted = ror_w[N-1:0];
      default: shifted = work;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too; they are few and a clean
      // restart keeps aborted operations from leaking stale operands.
      state  <= IDLE;
      work   <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
      cnt    <= '0;
      result <= '0;
      error  <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= A;
            mode_q <= mode;
            sign_q <= A[N-1];
            err_q  <= err_init;
            cnt    <= cnt_init;
            state  <= SHIFT;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end

        SHIFT: begin
          if (err_q || cnt == '0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= err_q ? '0 : work;
            error  <= err_q;
          end else begin
            work <= shifted;
            cnt  <= cnt_next;
            if (cnt_next == '0) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= shifted;
              error  <= 1'b0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: one instance at STEP=1, one at STEP=3,
// sharing stimulus; expected values are hand-computed constants.
module tb_seq_shift_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] mode;

  logic       ready1, busy1, done1, error1;
  logic [7:0] result1;
  logic       ready3, busy3, done3, error3;
  logic [7:0] result3;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LSL = 3'b000;
  localparam logic [2:0] LSR = 3'b001;
  localparam logic [2:0] ASR = 3'b010;
  localparam logic [2:0] SPL = 3'b011;
  localparam logic [2:0] ROL = 3'b100;
  localparam logic [2:0] ROR = 3'b101;
  localparam logic [2:0] BAD = 3'b110;

  always #5 clk = ~clk;

  seq_shift_unit #(.N(8), .STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready1), .busy(busy1),
    .A(A), .B(B), .mode(mode), .result(result1), .done(done1), .error(error1)
  );

  seq_shift_unit #(.N(8), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .ready(ready3), .busy(busy3),
    .A(A), .B(B), .mode(mode), .result(result3), .done(done3), .error(error3)
  );

  // Issue one request to both instances and capture result, error, latency
  // (edges from accept to done) and the STEP=1 busy cycle count.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                       output logic [7:0] r1, output logic [7:0] r3,
                       output logic e1, output logic e3,
                       output int l1, output int l3, output int bc1);
    int guard;
    guard = 0;
    while (!(ready1 && ready3) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    l1 = -1; l3 = -1; bc1 = 0;
    r1 = 8'hxx; r3 = 8'hxx; e1 = 1'bx; e3 = 1'bx;
    A = a; B = b; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy1) bc1++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (busy1) bc1++;
      if (done1 && l1 < 0) begin l1 = c; r1 = result1; e1 = error1; end
      if (done3 && l3 < 0) begin l3 = c; r3 = result3; e3 = error3; end
      if (l1 >= 0 && l3 >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; mode = LSL;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done1); end
    checks++; if (result1 !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result1); end
    checks++; if (error1 !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error1); end
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got %b want 1", ready3); end
    rst = 1'b0;
  endtask

  task automatic test_lsl();
    logic [7:0] r1, r3; logic e1, e3; int l1, l3, bc;
    issue(8'h13, 8'd2, LSL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h4C) begin errors++; $display("FAIL lsl_result got %h want 4c", r1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL lsl_error got %b want 0", e1); end
    checks++; if (l1 !== 2) begin errors++; $display("FAIL lsl_latency got %0d want 2", l1); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL lsl_busy_cycles got %0d want 2", bc); end
    checks++; if (r3 !== 8'h4C) begin errors++; $display("FAIL lsl_result_s3 got %h want 4c", r3); end
    checks++; if (l3 !== 1) begin errors++; $display("FAIL lsl_latency_s3 got %0d want 1", l3); end
  endtask

  task automatic test_modes();
    logic [7:0] r1, r3; logic e1, e3; int l1, l3, bc;
    issue(8'h96, 8'd3, ASR, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'hF2) begin errors++; $display("FAIL asr_result got %h want f2", r1); end
    checks++; if (r3 !== 8'hF2) begin errors++; $display("FAIL asr_result_s3 got %h want f2", r3); end
    checks++; if (l1 !== 3) begin errors++; $display("FAIL asr_latency got %0d want 3", l1); end
    issue(8'h96, 8'd3, LSR, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h12) begin errors++; $display("FAIL lsr_result got %h want 12", r1); end
    checks++; if (r3 !== 8'h12) begin errors++; $display("FAIL lsr_result_s3 got %h want 12", r3); end
    issue(8'hC3, 8'd2, SPL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h8C) begin errors++; $display("FAIL spl_result got %h want 8c", r1); end
    checks++; if (r3 !== 8'h8C) begin errors++; $display("FAIL spl_result_s3 got %h want 8c", r3); end
    issue(8'h81, 8'd1, ROR, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'hC0) begin errors++; $display("FAIL ror_result got %h want c0", r1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL ror_error got %b want 0", e1); end
  endtask

  task automatic test_errors();
    logic [7:0] r1, r3; logic e1, e3; int l1, l3, bc;
    issue(8'h55, 8'hFF, LSL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL negb_error got %b want 1", e1); end
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL negb_result got %h want 00", r1); end
    checks++; if (l1 !== 1) begin errors++; $display("FAIL negb_latency got %0d want 1", l1); end
    checks++; if (e3 !== 1'b1) begin errors++; $display("FAIL negb_error_s3 got %b want 1", e3); end
    issue(8'h55, 8'hFF, ROL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL negb_rol_error got %b want 1", e1); end
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL negb_rol_result got %h want 00", r1); end
    issue(8'h55, 8'd1, BAD, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL badmode_error got %b want 1", e1); end
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL badmode_result got %h want 00", r1); end
    checks++; if (l1 !== 1) begin errors++; $display("FAIL badmode_latency got %0d want 1", l1); end
    issue(8'h05, 8'd0, LSL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h05) begin errors++; $display("FAIL zero_amt_result got %h want 05", r1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL zero_amt_error got %b want 0", e1); end
    checks++; if (l1 !== 1) begin errors++; $display("FAIL zero_amt_latency got %0d want 1", l1); end
  endtask

  task automatic test_clamp();
    logic [7:0] r1, r3; logic e1, e3; int l1, l3, bc;
    issue(8'h81, 8'd20, LSL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL clamp_lsl_result got %h want 00", r1); end
    checks++; if (l1 !== 8) begin errors++; $display("FAIL clamp_lsl_latency got %0d want 8", l1); end
    checks++; if (l3 !== 3) begin errors++; $display("FAIL clamp_lsl_latency_s3 got %0d want 3", l3); end
    checks++; if (r3 !== 8'h00) begin errors++; $display("FAIL clamp_lsl_result_s3 got %h want 00", r3); end
    issue(8'h80, 8'd100, ASR, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL clamp_asr_result got %h want ff", r1); end
    checks++; if (r3 !== 8'hFF) begin errors++; $display("FAIL clamp_asr_result_s3 got %h want ff", r3); end
    checks++; if (l1 !== 8) begin errors++; $display("FAIL clamp_asr_latency got %0d want 8", l1); end
    issue(8'hC1, 8'd30, SPL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h80) begin errors++; $display("FAIL clamp_spl_result got %h want 80", r1); end
    issue(8'h81, 8'd9, ROL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r1 !== 8'h03) begin errors++; $display("FAIL wrap_rol_result got %h want 03", r1); end
    checks++; if (l1 !== 1) begin errors++; $display("FAIL wrap_rol_latency got %0d want 1", l1); end
  endtask

  task automatic test_step3_rol();
    logic [7:0] r1, r3; logic e1, e3; int l1, l3, bc;
    issue(8'h01, 8'd7, ROL, r1, r3, e1, e3, l1, l3, bc);
    checks++; if (r3 !== 8'h80) begin errors++; $display("FAIL step3_rol_result got %h want 80", r3); end
    checks++; if (l3 !== 3) begin errors++; $display("FAIL step3_rol_latency got %0d want 3", l3); end
    checks++; if (r1 !== 8'h80) begin errors++; $display("FAIL step1_rol_result got %h want 80", r1); end
    checks++; if (l1 !== 7) begin errors++; $display("FAIL step1_rol_latency got %0d want 7", l1); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] bsy, dn, rdy;
    int guard, accepts;
    guard = 0;
    while (!(ready1 && ready3) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    A = 8'h01; B = 8'd1; mode = LSL; start = 1'b1;
    bsy = '0; dn = '0; rdy = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bsy[c] = busy1; dn[c] = done1; rdy[c] = ready1;
    end
    start = 1'b0;
    accepts = 0;
    for (int c = 1; c <= 6; c++) if (bsy[c] && !bsy[c-1]) accepts++;
    checks++; if (dn[2] !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", dn[2]); end
    checks++; if (rdy[3] !== 1'b1 || bsy[3] !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_done got ready=%b busy=%b want 1/0", rdy[3], bsy[3]); end
    checks++; if (bsy[4] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b want 1", bsy[4]); end
    checks++; if (accepts !== 2) begin errors++; $display("FAIL b2b_accept_count got %0d want 2", accepts); end
    checks++; if (dn[5] !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", dn[5]); end
    checks++; if (result1 !== 8'h02) begin errors++; $display("FAIL b2b_result got %h want 02", result1); end
  endtask

  task automatic test_reset_mid();
    int guard, pulses;
    guard = 0;
    while (!(ready1 && ready3) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    A = 8'h81; B = 8'd20; mode = LSL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy1); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy1); end
    checks++; if (result1 !== 8'h00) begin errors++; $display("FAIL midrst_result got %h want 00", result1); end
    checks++; if (error1 !== 1'b0) begin errors++; $display("FAIL midrst_error got %b want 0", error1); end
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (done1 || done3) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_done_pulses got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_modes();
    test_errors();
    test_clamp();
    test_step3_rol();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
